// File: rtl/scan_pkg.sv
// Shared types and constants for the scan select sequencer and its slot finder.
package scan_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        GUARD  = 2'b10
    } state_t;

endpackage

// File: rtl/scan_sel_ctrl_slot_next_find.sv
// Combinational rotate-priority finder: first unmasked slot after cur_idx, checking
// cur_idx+1 .. cur_idx+4 mod NUM_SLOTS so the current slot is considered last.
module slot_next_find
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]     cur_idx,
    input  logic [NUM_SLOTS-1:0] mask,
    output logic [SEL_W-1:0]     next_idx,
    output logic                 found,
    output logic                 wrap
);

    logic [SEL_W-1:0] cand;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found    = 1'b0;
        next_idx = cur_idx;
        cand     = cur_idx;
        // Walk farthest-first so the nearest unmasked candidate is the last one written.
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            cand = cur_idx + SEL_W'(k);
            if (!mask[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
        wrap = found && (next_idx <= cur_idx);
    end

endmodule

// File: rtl/scan_sel_ctrl.sv
// Scan sequencer driving a 2-to-4 decoder: steps through unmasked slots with a
// programmable dwell and a one-cycle blanking guard between slots.
module scan_sel_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    input  logic               stop_in,
    input  logic               single_in,
    input  logic [DWELL_W-1:0] dwell_in,
    input  logic [3:0]         mask_in,
    output logic [SEL_W-1:0]   sel_out,
    output logic               en_out,
    output logic               busy_out,
    output logic               wrap_out,
    output logic               done_out
);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               single_q, single_d;
    logic [SEL_W-1:0]   sel_d;
    logic               wrap_d, done_d;

    logic [SEL_W-1:0]   find_cur, find_next;
    logic               find_found, find_wrap;

    // In IDLE the finder starts from the top slot so its first candidate is slot 0.
    assign find_cur = (state_q == IDLE) ? SEL_W'(NUM_SLOTS - 1) : sel_out;

    slot_next_find u_find (
        .cur_idx  (find_cur),
        .mask     (mask_in),
        .next_idx (find_next),
        .found    (find_found),
        .wrap     (find_wrap)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        single_d = single_q;
        sel_d    = sel_out;
        wrap_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_in && !stop_in && find_found) begin
                    state_d  = ACTIVE;
                    sel_d    = find_next;
                    cnt_d    = dwell_in;
                    single_d = single_in;
                end
            end
            ACTIVE: begin
                if (stop_in) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = GUARD;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            GUARD: begin
                if (stop_in || !find_found) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (find_wrap && single_q) begin
                    state_d = IDLE;
                    wrap_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ACTIVE;
                    wrap_d  = find_wrap;
                    sel_d   = find_next;
                    cnt_d   = dwell_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            sel_out  <= '0;
            en_out   <= 1'b0;
            busy_out <= 1'b0;
            wrap_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            sel_out  <= sel_d;
            en_out   <= (state_d == ACTIVE);
            busy_out <= (state_d != IDLE);
            wrap_out <= wrap_d;
            done_out <= done_d;
        end
    end

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Directed self-checking bench for scan_sel_ctrl with hand-computed expectations.
module tb_scan_sel_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       start_in, stop_in, single_in;
    logic [7:0] dwell_in;
    logic [3:0] mask_in;
    logic [1:0] sel_out;
    logic       en_out, busy_out, wrap_out, done_out;

    int checks = 0;
    int errors = 0;

    scan_sel_ctrl #(.DWELL_W(8)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start_in  (start_in),
        .stop_in   (stop_in),
        .single_in (single_in),
        .dwell_in  (dwell_in),
        .mask_in   (mask_in),
        .sel_out   (sel_out),
        .en_out    (en_out),
        .busy_out  (busy_out),
        .wrap_out  (wrap_out),
        .done_out  (done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic check_idle_outs(input string tag, input logic [1:0] sel);
        check({tag, " en"},   en_out,   1'b0);
        check({tag, " busy"}, busy_out, 1'b0);
        check({tag, " wrap"}, wrap_out, 1'b0);
        check({tag, " done"}, done_out, 1'b0);
        check({tag, " sel"},  sel_out,  sel);
    endtask

    initial begin
        rst_n_in  = 1'b0;
        start_in  = 1'b0;
        stop_in   = 1'b0;
        single_in = 1'b0;
        dwell_in  = 8'd0;
        mask_in   = 4'h0;
        tick();
        tick();
        check_idle_outs("reset", 2'd0);
        rst_n_in = 1'b1;
        tick();

        // Single pass over all four slots, dwell 2.
        mask_in = 4'h0; dwell_in = 8'd2; single_in = 1'b1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                check("t1 sel", sel_out, 8'(s));
                check("t1 en", en_out, 1'b1);
                check("t1 busy", busy_out, 1'b1);
                check("t1 wrap", wrap_out, 1'b0);
                tick();
            end
            check("t1 guard en", en_out, 1'b0);
            check("t1 guard busy", busy_out, 1'b1);
            tick();
        end
        check("t1 end wrap", wrap_out, 1'b1);
        check("t1 end done", done_out, 1'b1);
        check("t1 end busy", busy_out, 1'b0);
        check("t1 end en", en_out, 1'b0);
        check("t1 end sel", sel_out, 2'd3);
        tick();
        check_idle_outs("t1 after", 2'd3);

        // Alternating slots 0/2 with 1-cycle dwell, continuous, then stop during slot 2.
        mask_in = 4'b1010; dwell_in = 8'd0; single_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2 sel", sel_out, (i % 2) ? 8'd2 : 8'd0);
            check("t2 en", en_out, 1'b1);
            check("t2 wrap", wrap_out, (i > 0 && i % 2 == 0) ? 8'd1 : 8'd0);
            check("t2 done", done_out, 1'b0);
            tick();
            check("t2 guard en", en_out, 1'b0);
            check("t2 guard wrap", wrap_out, 1'b0);
            tick();
        end
        check("t2 stop pre sel", sel_out, 2'd2);
        check("t2 stop pre en", en_out, 1'b1);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("t2 stop en", en_out, 1'b0);
        check("t2 stop busy", busy_out, 1'b0);
        check("t2 stop done", done_out, 1'b1);
        check("t2 stop sel", sel_out, 2'd2);
        check("t2 stop wrap", wrap_out, 1'b0);
        tick();
        check("t2 stop done clr", done_out, 1'b0);

        // Only slot 1 unmasked: wraps every guard; then mask all during ACTIVE.
        mask_in = 4'b1101; dwell_in = 8'd1; single_in = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3 sel", sel_out, 2'd1);
            check("t3 wrap", wrap_out, (i > 0) ? 8'd1 : 8'd0);
            check("t3 en", en_out, 1'b1);
            tick();
            check("t3 en2", en_out, 1'b1);
            check("t3 wrap2", wrap_out, 1'b0);
            tick();
            check("t3 guard en", en_out, 1'b0);
            check("t3 guard busy", busy_out, 1'b1);
            tick();
        end
        check("t3 last sel", sel_out, 2'd1);
        mask_in = 4'hF;
        tick();
        check("t3 mf en", en_out, 1'b1);
        tick();
        check("t3 mf guard en", en_out, 1'b0);
        check("t3 mf guard busy", busy_out, 1'b1);
        tick();
        check("t3 mf done", done_out, 1'b1);
        check("t3 mf wrap", wrap_out, 1'b0);
        check("t3 mf busy", busy_out, 1'b0);
        check("t3 mf sel", sel_out, 2'd1);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check_idle_outs("t3 start masked", 2'd1);

        // Asynchronous reset in the middle of a slot.
        mask_in = 4'b0011; dwell_in = 8'd5; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("t4 sel", sel_out, 2'd2);
        check("t4 en", en_out, 1'b1);
        tick();
        #2 rst_n_in = 1'b0;
        #1 check_idle_outs("t4 async rst", 2'd0);
        tick();
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outs("t4 post rst", 2'd0);
        end
        mask_in = 4'h0; dwell_in = 8'd0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("t4 restart sel", sel_out, 2'd0);
        check("t4 restart en", en_out, 1'b1);
        check("t4 restart busy", busy_out, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
